// File: rtl/mips_mem_pkg.sv
// rtl/mips_mem_pkg.sv - shared encodings for the unified memory port arbiter
package mips_mem_pkg;
  localparam int DEFAULT_AW = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_t;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester and memory side signals of the arbiter
interface mem_port_arbiter_if
  import mips_mem_pkg::*;
#(
  parameter int AW = DEFAULT_AW
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [31:0]   if_rdata;
  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [31:0]   dm_wdata;
  logic          dm_gnt;
  logic          dm_rvalid;
  logic [31:0]   dm_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  logic          busy;

  modport master (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport slave (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_starve_ctr.sv
// rtl/mem_starve_ctr.sv - saturating fetch-starvation counter and priority decision
module mem_starve_ctr #(
  parameter int STARVE_MAX = 3
) (
  input  logic clk1,
  input  logic rst,
  input  logic i_arb,
  input  logic i_if_req,
  input  logic i_dm_req,
  output logic o_if_wins
);
  logic [3:0] r_cnt;
  logic       w_at_max;

  assign w_at_max  = (r_cnt == 4'(STARVE_MAX));
  assign o_if_wins = i_if_req && (!i_dm_req || w_at_max);

  // Only a lost contested arbitration counts; a sole DM request leaves it alone.
  always_ff @(posedge clk1) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_arb) begin
      if (o_if_wins) begin
        r_cnt <= '0;
      end else if (i_if_req && !w_at_max) begin
        r_cnt <= r_cnt + 4'd1;
      end
    end
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - serialises IF and DM accesses onto one memory port
module mem_port_arbiter
  import mips_mem_pkg::*;
#(
  parameter int AW         = DEFAULT_AW,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 3
) (
  input logic                clk1,
  input logic                rst,
  mem_port_arbiter_if.master bus
);
  state_t        r_state, w_state;
  owner_t        r_owner, w_owner;
  logic [3:0]    r_lat_cnt, w_lat_cnt;
  logic          r_is_store, w_is_store;
  logic          r_if_gnt, w_if_gnt, r_dm_gnt, w_dm_gnt;
  logic          r_if_rvalid, w_if_rvalid, r_dm_rvalid, w_dm_rvalid;
  logic [31:0]   r_if_rdata, w_if_rdata, r_dm_rdata, w_dm_rdata;
  logic          r_mem_en, w_mem_en, r_mem_we, w_mem_we;
  logic [AW-1:0] r_mem_addr, w_mem_addr;
  logic [31:0]   r_mem_wdata, w_mem_wdata;
  logic          r_busy, w_busy;
  logic          w_arb, w_if_wins;

  assign w_arb = ((r_state == IDLE) || (r_state == RESP)) && (bus.if_req || bus.dm_req);

  mem_starve_ctr #(.STARVE_MAX(STARVE_MAX)) u_starve (
    .clk1      (clk1),
    .rst       (rst),
    .i_arb     (w_arb),
    .i_if_req  (bus.if_req),
    .i_dm_req  (bus.dm_req),
    .o_if_wins (w_if_wins)
  );

  always_comb begin
    w_state     = r_state;
    w_owner     = r_owner;
    w_lat_cnt   = r_lat_cnt;
    w_is_store  = r_is_store;
    w_if_gnt    = 1'b0;
    w_dm_gnt    = 1'b0;
    w_if_rvalid = 1'b0;
    w_dm_rvalid = 1'b0;
    w_if_rdata  = r_if_rdata;
    w_dm_rdata  = r_dm_rdata;
    w_mem_en    = 1'b0;
    w_mem_we    = 1'b0;
    w_mem_addr  = r_mem_addr;
    w_mem_wdata = r_mem_wdata;
    w_busy      = 1'b0;
    case (r_state)
      IDLE, RESP: begin
        w_state = IDLE;
        if (w_arb) begin
          w_state   = WAIT;
          w_lat_cnt = 4'(MEM_LAT);
          w_mem_en  = 1'b1;
          w_busy    = 1'b1;
          if (w_if_wins) begin
            w_owner    = OWN_IF;
            w_if_gnt   = 1'b1;
            w_mem_addr = bus.if_addr;
            w_is_store = 1'b0;
          end else begin
            w_owner     = OWN_DM;
            w_dm_gnt    = 1'b1;
            w_mem_addr  = bus.dm_addr;
            w_mem_we    = bus.dm_we;
            w_mem_wdata = bus.dm_wdata;
            w_is_store  = bus.dm_we;
          end
        end
      end
      WAIT: begin
        // Counter reaches zero in the cycle the memory presents read data.
        if (r_lat_cnt == 4'd0) begin
          w_state = RESP;
          if (r_owner == OWN_IF) begin
            w_if_rvalid = 1'b1;
            w_if_rdata  = bus.mem_rdata;
          end else begin
            w_dm_rvalid = 1'b1;
            w_dm_rdata  = r_is_store ? 32'd0 : bus.mem_rdata;
          end
        end else begin
          w_lat_cnt = r_lat_cnt - 4'd1;
          w_busy    = 1'b1;
        end
      end
      default: w_state = IDLE;
    endcase
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      r_state     <= IDLE;
      r_owner     <= OWN_IF;
      r_lat_cnt   <= '0;
      r_is_store  <= 1'b0;
      r_if_gnt    <= 1'b0;
      r_dm_gnt    <= 1'b0;
      r_if_rvalid <= 1'b0;
      r_dm_rvalid <= 1'b0;
      r_if_rdata  <= '0;
      r_dm_rdata  <= '0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_owner     <= w_owner;
      r_lat_cnt   <= w_lat_cnt;
      r_is_store  <= w_is_store;
      r_if_gnt    <= w_if_gnt;
      r_dm_gnt    <= w_dm_gnt;
      r_if_rvalid <= w_if_rvalid;
      r_dm_rvalid <= w_dm_rvalid;
      r_if_rdata  <= w_if_rdata;
      r_dm_rdata  <= w_dm_rdata;
      r_mem_en    <= w_mem_en;
      r_mem_we    <= w_mem_we;
      r_mem_addr  <= w_mem_addr;
      r_mem_wdata <= w_mem_wdata;
      r_busy      <= w_busy;
    end
  end

  assign bus.if_gnt    = r_if_gnt;
  assign bus.dm_gnt    = r_dm_gnt;
  assign bus.if_rvalid = r_if_rvalid;
  assign bus.dm_rvalid = r_dm_rvalid;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.dm_rdata  = r_dm_rdata;
  assign bus.mem_en    = r_mem_en;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.busy      = r_busy;
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-ported 1024x32 unified instruction/data memory between two requesters: the instruction-fetch stage (IF port) and the load/store stage (DM port).
- Serialises accesses and drives the memory's address, enable and write controls.
- Returns read data to whichever requester owns the current access.
- Data accesses win by default; a starvation counter guarantees fetch progress.

Parameters:
- AW, 10: memory word-address width.
- MEM_LAT, 1: memory read latency in cycles. Legal range is 1..15.
- STARVE_MAX, 3: number of consecutive lost arbitrations after which IF wins once. Legal range is 1..15.

Ports:
- clk1  in  1  single system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- if_req  in  1  fetch request (read only). Level signal.
- if_addr  in  AW  fetch word address.
- if_gnt  out  1  one-cycle pulse when the fetch request is accepted.
- if_rvalid  out  1  one-cycle pulse when if_rdata is valid.
- if_rdata  out  32  fetched instruction word.
- dm_req  in  1  data request. Level signal.
- dm_we  in  1  1 = store, 0 = load.
- dm_addr  in  AW  data word address.
- dm_wdata  in  32  store data.
- dm_gnt  out  1  one-cycle pulse when the data request is accepted.
- dm_rvalid  out  1  one-cycle completion pulse, for loads and stores.
- dm_rdata  out  32  load data. Always 0 on store completion.
- mem_en  out  1  memory access strobe, one cycle per access.
- mem_we  out  1  memory write enable. Qualified by mem_en.
- mem_addr  out  AW  memory word address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data. Valid MEM_LAT cycles after the mem_en cycle.
- busy  out  1  high while an access is outstanding (state is not IDLE).

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE.
  - Owner = IF.
  - starve_cnt = 0.
  - Latency counter 0.
- Reset mid-access: the access is aborted. No rvalid or gnt is produced afterwards. A store already strobed is not retracted.
- All outputs are registered.
- States:
  - IDLE: samples requests at each rising edge.
    - No request: stay in IDLE.
    - Any request: register the winner as owner. Drive mem_en=1 with mem_addr/mem_we/mem_wdata from the winner and the matching gnt=1 for exactly one cycle (cycle T). Go to WAIT with lat_cnt = MEM_LAT.
  - WAIT: lat_cnt decrements each cycle. Requests are ignored. gnt and mem_en are 0.
    - In cycle T+MEM_LAT, capture mem_rdata (0 for stores) and go to RESP.
  - RESP (cycle T+MEM_LAT+1): the owner's rvalid=1 with rdata. The other port's rvalid stays 0. Requests are sampled exactly as in IDLE, so the next gnt can occur at T+MEM_LAT+2.
- Timing:
  - Request-to-completion latency: request seen at the edge ending cycle T-1, completion at T+MEM_LAT+1.
  - Peak throughput: one access per MEM_LAT+2 cycles.
- Handshake:
  - A requester holds req and its address/data stable until it sees gnt, then may drop req.
  - req still high in the cycle after gnt counts as a new request.
  - rdata holds its value until the next capture. rvalid is the only qualifier.
- Arbitration, applied when both ports request in the same sampling edge:
  - If starve_cnt == STARVE_MAX: IF wins and starve_cnt is cleared.
  - Otherwise: DM wins and starve_cnt increments, saturating at STARVE_MAX.
  - Any IF grant, contested or not, clears starve_cnt.
  - A sole DM request leaves starve_cnt unchanged.
- Address width: mem_addr is taken unmodified from the requester. No wrap or range check; the upper bound is the memory's concern.

Decomposition:
- Shared package mips_mem_pkg:
  - State encoding: IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2.
  - Owner encoding: OWN_IF = 1'b0, OWN_DM = 1'b1.
  - Default AW = 10.
- One natural sub-module, mem_starve_ctr: the saturating starvation counter with its grant-priority decision output, so the policy can be verified alone.

Test Plan:
- MEM_LAT=1, mem preloaded Mem[5]=32'hDEADBEEF. Assert if_req, if_addr=5 for one sampling edge:
  - if_gnt and mem_en high in cycle T with mem_addr=5.
  - if_rvalid=1 with if_rdata=32'hDEADBEEF at T+2.
  - dm_rvalid stays 0.
- Simultaneous if_req (addr 1) and dm_req load (addr 2):
  - DM granted first, dm_rvalid at T+2.
  - IF granted at T+3.
- Store: dm_req, dm_we=1, dm_addr=9, dm_wdata=32'h12345678:
  - mem_en=mem_we=1, mem_wdata correct for one cycle.
  - dm_rvalid at T+2 with dm_rdata=0.
  - A later IF read of address 9 returns 32'h12345678.
- STARVE_MAX=3, if_req and dm_req held high continuously:
  - Grant sequence DM,DM,DM,IF, repeating.
  - starve_cnt reaches 3 before the IF grant and is 0 after it.
- MEM_LAT=3, single DM load of address 7 = 32'hA5A5A5A5:
  - busy high for cycles T..T+3.
  - dm_rvalid with 32'hA5A5A5A5 at T+4.
- rst pulsed at T+1 of a MEM_LAT=3 load:
  - All outputs 0 from the next cycle.
  - No dm_rvalid ever appears.
  - A fresh if_req afterwards completes normally.
